multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 82 ++++++++
 rtl/instr_decode.sv | 26 ++
 rtl/multicycle_ctrl.sv | 127 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types, opcode constants and encodings for the multicycle control unit.
package ctrl_pkg;

  localparam int unsigned OP_W      = 7;
  localparam int unsigned F3_W      = 3;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned CLS_W     = 3;
  localparam int unsigned ALUCTRL_W = 3;
  localparam int unsigned IMMSRC_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Zero encoding doubles as the cleared value of the class register.
  typedef enum logic [CLS_W-1:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_ADDI    = 3'd1,
    CLS_ADD     = 3'd2,
    CLS_SUB     = 3'd3,
    CLS_LW      = 3'd4,
    CLS_SW      = 3'd5,
    CLS_BNE     = 3'd6
  } instr_class_t;

  localparam logic [OP_W-1:0] OP_OP_IMM = 7'b0010011;
  localparam logic [OP_W-1:0] OP_OP     = 7'b0110011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [F3_W-1:0] F3_ADD = 3'b000;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_SW  = 3'b010;
  localparam logic [F3_W-1:0] F3_BNE = 3'b001;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b001;

  localparam logic [IMMSRC_W-1:0] IMM_I = 2'b00;
  localparam logic [IMMSRC_W-1:0] IMM_S = 2'b01;
  localparam logic [IMMSRC_W-1:0] IMM_B = 2'b10;

  // Control word driven onto the datapath each cycle.
  typedef struct packed {
    logic                 imem_req;
    logic                 dmem_req;
    logic                 pc_write;
    logic                 ir_write;
    logic                 reg_write;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic                 alu_src;
    logic [IMMSRC_W-1:0]  imm_src;
    logic                 pc_src;
    logic                 result_src;
    logic                 mem_write;
  } ctrl_sig_t;

  function automatic logic uses_imm(input instr_class_t cls);
    return (cls == CLS_ADDI) || (cls == CLS_LW) || (cls == CLS_SW);
  endfunction

  function automatic logic [ALUCTRL_W-1:0] alu_ctrl_of(input instr_class_t cls);
    return ((cls == CLS_SUB) || (cls == CLS_BNE)) ? ALU_SUB : ALU_ADD;
  endfunction

  function automatic logic [IMMSRC_W-1:0] imm_src_of(input instr_class_t cls);
    logic [IMMSRC_W-1:0] imm;
    case (cls)
      CLS_SW:  imm = IMM_S;
      CLS_BNE: imm = IMM_B;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction classifier: opcode/funct fields to class and legal flag.
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [F3_W-1:0] funct3,
  input  logic            func7_5,
  output instr_class_t    cls,
  output logic            legal
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (op)
      OP_OP_IMM: if (funct3 == F3_ADD) cls = CLS_ADDI;
      OP_OP:     if (funct3 == F3_ADD) cls = func7_5 ? CLS_SUB : CLS_ADD;
      OP_LOAD:   if (funct3 == F3_LW)  cls = CLS_LW;
      OP_STORE:  if (funct3 == F3_SW)  cls = CLS_SW;
      OP_BRANCH: if (funct3 == F3_BNE) cls = CLS_BNE;
      default:   cls = CLS_ILLEGAL;
    endcase
  end

  assign legal = (cls != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back for a small RISC-V subset.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_W-1:0]      op,
  input  logic [F3_W-1:0]      funct3,
  input  logic                 func7_5,
  input  logic                 Zero,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [ALUCTRL_W-1:0] ALUctrl,
  output logic                 ALUsrc,
  output logic [IMMSRC_W-1:0]  ImmSrc,
  output logic                 PCsrc,
  output logic                 ResultSrc,
  output logic                 MemWrite,
  output logic                 illegal,
  output logic [STATE_W-1:0]   state
);

  state_t       state_q;
  instr_class_t cls_q;
  instr_class_t dec_cls;
  logic         dec_legal;
  logic         illegal_q;
  ctrl_sig_t    sig;

  instr_decode u_decode (
    .op      (op),
    .funct3  (funct3),
    .func7_5 (func7_5),
    .cls     (dec_cls),
    .legal   (dec_legal)
  );

  // State, latched class and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      cls_q     <= CLS_ILLEGAL;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ready) state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          cls_q <= dec_cls;
          if (dec_legal) begin
            state_q <= ST_EXEC;
          end else begin
            state_q   <= ST_HALT;
            illegal_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_ADDI, CLS_ADD, CLS_SUB: state_q <= ST_WB;
            CLS_LW, CLS_SW:             state_q <= ST_MEM;
            CLS_BNE:                    state_q <= ST_FETCH;
            default:                    state_q <= ST_HALT;
          endcase
        end
        ST_MEM: begin
          if (dmem_ready) state_q <= (cls_q == CLS_LW) ? ST_WB : ST_FETCH;
        end
        ST_WB:   state_q <= ST_FETCH;
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_HALT;
      endcase
    end
  end

  // Output decode; the ready and Zero terms only qualify the one-cycle PC/IR strobes.
  always_comb begin
    sig = '0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          sig.imem_req = 1'b1;
          sig.ir_write = imem_ready;
          sig.pc_write = imem_ready;
        end
        ST_EXEC: begin
          sig.alu_src  = uses_imm(cls_q);
          sig.alu_ctrl = alu_ctrl_of(cls_q);
          sig.imm_src  = imm_src_of(cls_q);
          if ((cls_q == CLS_BNE) && !Zero) begin
            sig.pc_write = 1'b1;
            sig.pc_src   = 1'b1;
          end
        end
        ST_MEM: begin
          sig.dmem_req  = 1'b1;
          sig.mem_write = (cls_q == CLS_SW);
        end
        ST_WB: begin
          sig.reg_write  = 1'b1;
          sig.result_src = (cls_q == CLS_LW);
        end
        default: sig = '0;
      endcase
    end
  end

  assign imem_req  = sig.imem_req;
  assign dmem_req  = sig.dmem_req;
  assign PCWrite   = sig.pc_write;
  assign IRWrite   = sig.ir_write;
  assign RegWrite  = sig.reg_write;
  assign ALUctrl   = sig.alu_ctrl;
  assign ALUsrc    = sig.alu_src;
  assign ImmSrc    = sig.imm_src;
  assign PCsrc     = sig.pc_src;
  assign ResultSrc = sig.result_src;
  assign MemWrite  = sig.mem_write;
  assign illegal   = illegal_q & ~rst;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed cycle-by-cycle bench for multicycle_ctrl with hand-computed control words.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       func7_5;
  logic       Zero;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req, dmem_req, PCWrite, IRWrite, RegWrite;
  logic [2:0] ALUctrl;
  logic       ALUsrc;
  logic [1:0] ImmSrc;
  logic       PCsrc, ResultSrc, MemWrite, illegal;
  logic [2:0] state;
  logic [17:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .func7_5(func7_5), .Zero(Zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc),
    .PCsrc(PCsrc), .ResultSrc(ResultSrc), .MemWrite(MemWrite), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  // {state, imem_req, dmem_req, PCWrite, IRWrite, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc, ResultSrc, MemWrite, illegal}
  assign obs = {state, imem_req, dmem_req, PCWrite, IRWrite, RegWrite, ALUctrl, ALUsrc, ImmSrc,
                PCsrc, ResultSrc, MemWrite, illegal};

  // rq = {imem_req, dmem_req, PCWrite, IRWrite, RegWrite}; ms = {PCsrc, ResultSrc, MemWrite, illegal}
  function automatic logic [17:0] ev(input logic [2:0] st, input logic [4:0] rq,
                                     input logic [2:0] aluc, input logic alus,
                                     input logic [1:0] imm, input logic [3:0] ms);
    return {st, rq, aluc, alus, imm, ms};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check the current cycle's outputs, then advance one clock.
  task automatic tick(input string tag, input logic [17:0] exp);
    #1;
    check(tag, 32'(obs), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; func7_5 = f7;
  endtask

  task automatic junk_instr();
    op = 7'h7f; funct3 = 3'b111; func7_5 = 1'b1;
  endtask

  logic [17:0] FETCH_OK, FETCH_WAIT, DEC;

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    FETCH_OK   = ev(3'd0, 5'b10110, 3'b000, 1'b0, 2'b00, 4'b0000);
    FETCH_WAIT = ev(3'd0, 5'b10000, 3'b000, 1'b0, 2'b00, 4'b0000);
    DEC        = ev(3'd1, 5'b00000, 3'b000, 1'b0, 2'b00, 4'b0000);

    rst = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; Zero = 1'b0;
    junk_instr();
    @(posedge clk); #1;
    tick("reset_hold", ev(3'd0, 5'b00000, 3'b000, 1'b0, 2'b00, 4'b0000));
    rst = 1'b0;

    // ADDI x1,x0,5; opcode garbage outside DECODE must not matter
    tick("addi_fetch", FETCH_OK);
    set_instr(7'b0010011, 3'b000, 1'b0);
    tick("addi_decode", DEC);
    junk_instr();
    tick("addi_exec", ev(3'd2, 5'b00000, 3'b000, 1'b1, 2'b00, 4'b0000));
    tick("addi_wb", ev(3'd4, 5'b00001, 3'b000, 1'b0, 2'b00, 4'b0000));

    // SUB with three imem wait cycles; stray dmem_ready during FETCH is ignored
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick("sub_fetch_wait", FETCH_WAIT);
    imem_ready = 1'b1;
    tick("sub_fetch", FETCH_OK);
    set_instr(7'b0110011, 3'b000, 1'b1);
    tick("sub_decode", DEC);
    junk_instr();
    tick("sub_exec", ev(3'd2, 5'b00000, 3'b001, 1'b0, 2'b00, 4'b0000));
    tick("sub_wb", ev(3'd4, 5'b00001, 3'b000, 1'b0, 2'b00, 4'b0000));

    // ADD
    tick("add_fetch", FETCH_OK);
    set_instr(7'b0110011, 3'b000, 1'b0);
    tick("add_decode", DEC);
    junk_instr();
    tick("add_exec", ev(3'd2, 5'b00000, 3'b000, 1'b0, 2'b00, 4'b0000));
    tick("add_wb", ev(3'd4, 5'b00001, 3'b000, 1'b0, 2'b00, 4'b0000));

    // LW with two dmem wait cycles
    tick("lw_fetch", FETCH_OK);
    set_instr(7'b0000011, 3'b010, 1'b0);
    tick("lw_decode", DEC);
    junk_instr();
    tick("lw_exec", ev(3'd2, 5'b00000, 3'b000, 1'b1, 2'b00, 4'b0000));
    dmem_ready = 1'b0;
    tick("lw_mem_wait", ev(3'd3, 5'b01000, 3'b000, 1'b0, 2'b00, 4'b0000));
    tick("lw_mem_wait", ev(3'd3, 5'b01000, 3'b000, 1'b0, 2'b00, 4'b0000));
    dmem_ready = 1'b1;
    tick("lw_mem", ev(3'd3, 5'b01000, 3'b000, 1'b0, 2'b00, 4'b0000));
    tick("lw_wb", ev(3'd4, 5'b00001, 3'b000, 1'b0, 2'b00, 4'b0100));

    // SW, zero wait
    tick("sw_fetch", FETCH_OK);
    set_instr(7'b0100011, 3'b010, 1'b0);
    tick("sw_decode", DEC);
    junk_instr();
    tick("sw_exec", ev(3'd2, 5'b00000, 3'b000, 1'b1, 2'b01, 4'b0000));
    tick("sw_mem", ev(3'd3, 5'b01000, 3'b000, 1'b0, 2'b00, 4'b0010));

    // BNE taken (Zero=0)
    tick("bne_nz_fetch", FETCH_OK);
    set_instr(7'b1100011, 3'b001, 1'b0);
    Zero = 1'b1;
    tick("bne_nz_decode", DEC);
    junk_instr();
    Zero = 1'b0;
    tick("bne_nz_exec", ev(3'd2, 5'b00100, 3'b001, 1'b0, 2'b10, 4'b1000));

    // BNE not taken (Zero=1)
    tick("bne_z_fetch", FETCH_OK);
    set_instr(7'b1100011, 3'b001, 1'b0);
    tick("bne_z_decode", DEC);
    junk_instr();
    Zero = 1'b1;
    tick("bne_z_exec", ev(3'd2, 5'b00000, 3'b001, 1'b0, 2'b10, 4'b0000));
    Zero = 1'b0;

    // Illegal opcode halts with sticky flag
    tick("ill_fetch", FETCH_OK);
    set_instr(7'b1111111, 3'b000, 1'b0);
    tick("ill_decode", DEC);
    for (int i = 0; i < 20; i++) begin
      set_instr(7'b0010011, 3'b000, 1'b0);
      Zero = i[0];
      tick("ill_halt", ev(3'd5, 5'b00000, 3'b000, 1'b0, 2'b00, 4'b0001));
    end
    Zero = 1'b0;
    junk_instr();
    rst = 1'b1;
    tick("ill_rst_assert", ev(3'd5, 5'b00000, 3'b000, 1'b0, 2'b00, 4'b0000));
    tick("ill_rst_hold", ev(3'd0, 5'b00000, 3'b000, 1'b0, 2'b00, 4'b0000));
    rst = 1'b0;

    // ADD after recovery
    tick("rec_fetch", FETCH_OK);
    set_instr(7'b0110011, 3'b000, 1'b0);
    tick("rec_decode", DEC);
    junk_instr();
    tick("rec_exec", ev(3'd2, 5'b00000, 3'b000, 1'b0, 2'b00, 4'b0000));
    tick("rec_wb", ev(3'd4, 5'b00001, 3'b000, 1'b0, 2'b00, 4'b0000));

    // SW interrupted by reset while waiting in MEM
    tick("swr_fetch", FETCH_OK);
    set_instr(7'b0100011, 3'b010, 1'b0);
    tick("swr_decode", DEC);
    junk_instr();
    tick("swr_exec", ev(3'd2, 5'b00000, 3'b000, 1'b1, 2'b01, 4'b0000));
    dmem_ready = 1'b0;
    tick("swr_mem", ev(3'd3, 5'b01000, 3'b000, 1'b0, 2'b00, 4'b0010));
    rst = 1'b1;
    tick("swr_rst_assert", ev(3'd3, 5'b00000, 3'b000, 1'b0, 2'b00, 4'b0000));
    dmem_ready = 1'b1;
    tick("swr_rst_next", ev(3'd0, 5'b00000, 3'b000, 1'b0, 2'b00, 4'b0000));
    rst = 1'b0;
    tick("swr_release", FETCH_OK);
    tick("swr_after", DEC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
